adc_capture: RTL and testbench

- Receive-side counterpart of the ADC emulator.
- Samples the WIDTH-bit `link` bus on each `strobe` pulse and packs sample pairs into 2*WIDTH-bit words.
- Buffers packed words in a small first-word-fall-through FIFO and presents them on a valid/ready stream toward the DMA write path.
- Reports overflow and dropped-word statistics; an optional continuity checker validates the emulator's triangle ramp.

---
 rtl/adc_capture_if.sv | 15 +
 rtl/adc_capture.sv | 155 +++++++++++++++
 tb/tb_adc_capture.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_if.sv
// adc_capture_if -- packed-word stream from adc_capture toward the DMA write path.
//   m_data  : packed word {second sample, first sample}, 2*WIDTH bits
//   m_valid : a word is present (FIFO non-empty)
//   m_ready : downstream accepts the presented word
// Modports: master (capture side), slave (consumer side).
interface adc_capture_if #(
    parameter int WIDTH = 16
);
    logic [2*WIDTH-1:0] m_data;
    logic               m_valid;
    logic               m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/adc_capture.sv
// adc_capture -- receive side of the ADC emulator link.
// Captures `link` on each enabled `strobe` cycle, packs sample pairs into
// {second, first} words and buffers them in a first-word-fall-through FIFO
// presented on the `stream` interface (m_data/m_valid/m_ready).
// Ports:
//   clk, reset (async, active-low)
//   enable    capture enable; low discards any half-packed word
//   link      WIDTH-bit sample, strobe = capture qualifier (level-sampled)
//   clear     sync clear of overflow, drop_cnt (and chk_cnt)
//   stream    master modport of adc_capture_if
//   overflow  sticky drop flag, drop_cnt saturating drop count
//   fill      FIFO occupancy
//   chk_err / chk_cnt  ramp continuity checker, built only when the macro
//             ADC_CAPTURE_CHECK_EN is defined; otherwise tied to 0.
module adc_capture #(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int ACC_STEP   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [WIDTH-1:0]             link,
    input  logic                         strobe,
    input  logic                         clear,
    adc_capture_if.master                stream,
    output logic                         overflow,
    output logic [15:0]                  drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]  fill,
    output logic                         chk_err,
    output logic [15:0]                  chk_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {LOW, HIGH} pack_t;

    pack_t              state;
    logic [WIDTH-1:0]   hold;
    logic [2*WIDTH-1:0] mem [FIFO_DEPTH];
    logic [2*WIDTH-1:0] last;
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               capture;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               accept;
    logic               drop;

    assign capture = enable & strobe;
    assign push    = capture && (state == HIGH);
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && stream.m_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO is kept.
    assign accept  = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign fill    = wr_ptr - rd_ptr;

    assign stream.m_valid = !empty;
    // While empty, show the last popped word (or 0 after reset) rather than a stale slot.
    assign stream.m_data  = empty ? last : mem[rd_ptr[AW-1:0]];

    // Pack FSM: LOW holds the first sample, HIGH completes the word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOW;
            hold  <= '0;
        end else if (!enable) begin
            state <= LOW;
        end else if (strobe) begin
            case (state)
                LOW: begin
                    hold  <= link;
                    state <= HIGH;
                end
                HIGH:    state <= LOW;
                default: state <= LOW;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= {link, hold};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last   <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last   <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // A drop in the same cycle as clear wins: count restarts at 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear)                  drop_cnt <= 16'd1;
            else if (drop_cnt != '1)    drop_cnt <= drop_cnt + 16'd1;
        end else if (clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

`ifdef ADC_CAPTURE_CHECK_EN
    localparam logic [WIDTH-1:0] STEP = WIDTH'(ACC_STEP);

    logic [WIDTH-1:0] prev;
    logic             first;
    logic [WIDTH-1:0] diff;
    logic             bad;

    assign diff = (link >= prev) ? (link - prev) : (prev - link);
    assign bad  = capture && !first && (diff != STEP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev    <= '0;
            first   <= 1'b1;
            chk_err <= 1'b0;
            chk_cnt <= '0;
        end else begin
            chk_err <= bad;
            if (!enable) begin
                first <= 1'b1;
            end else if (strobe) begin
                first <= 1'b0;
                prev  <= link;
            end
            if (bad) begin
                if (clear)               chk_cnt <= 16'd1;
                else if (chk_cnt != '1)  chk_cnt <= chk_cnt + 16'd1;
            end else if (clear) begin
                chk_cnt <= '0;
            end
        end
    end
`else
    assign chk_err = 1'b0;
    assign chk_cnt = '0;
`endif

endmodule

// File: tb/tb_adc_capture.sv
module tb_adc_capture;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] link = '0;
    logic        strobe = 1'b0;
    logic        clear = 1'b0;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [3:0]  fill;
    logic        chk_err;
    logic [15:0] chk_cnt;

    adc_capture_if #(.WIDTH(16)) s_if ();

    adc_capture #(.WIDTH(16), .FIFO_DEPTH(DEPTH), .ACC_STEP(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .link     (link),
        .strobe   (strobe),
        .clear    (clear),
        .stream   (s_if),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .fill     (fill),
        .chk_err  (chk_err),
        .chk_cnt  (chk_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a queue of words, a pending half word, counters.
    logic [31:0] q[$];
    logic [15:0] pend;
    bit          have_pend = 0;
    bit          exp_ovf = 0;
    int          exp_drops = 0;
    int          words_made = 0;
    bit          chk_first = 1;
    int          chk_prev = 0;
    int          exp_chk_cnt = 0;
    bit          exp_chk_err = 0;
    int          obs_pulses = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, check the presented word, update the model
    // for the coming edge, then check state just after the edge.
    task automatic step(input bit en, input bit st, input logic [15:0] ln,
                        input bit rdy, input bit clr);
        logic [31:0] w;
        bit          push;
        int          d;
        @(negedge clk);
        enable = en; strobe = st; link = ln; s_if.m_ready = rdy; clear = clr;
        #1;
        check("m_valid", s_if.m_valid, q.size() != 0);
        if (q.size() != 0) check("m_data", s_if.m_data, q[0]);

        if (q.size() != 0 && rdy) void'(q.pop_front());
        push = 0;
        w = '0;
        if (!en) have_pend = 0;
        else if (st) begin
            if (!have_pend) begin pend = ln; have_pend = 1; end
            else begin w = {ln, pend}; push = 1; have_pend = 0; words_made++; end
        end
        if (clr) begin exp_ovf = 0; exp_drops = 0; end
        if (push) begin
            if (q.size() < DEPTH) q.push_back(w);
            else begin
                exp_ovf = 1;
                if (exp_drops < 65535) exp_drops++;
            end
        end

        exp_chk_err = 0;
`ifdef ADC_CAPTURE_CHECK_EN
        if (clr) exp_chk_cnt = 0;
        if (!en) chk_first = 1;
        else if (st) begin
            if (!chk_first) begin
                d = int'(ln) - chk_prev;
                if (d < 0) d = -d;
                if (d != 1) begin
                    exp_chk_err = 1;
                    if (exp_chk_cnt < 65535) exp_chk_cnt++;
                end
            end
            chk_first = 0;
            chk_prev = int'(ln);
        end
`else
        d = 0;
`endif

        @(posedge clk);
        #1;
        check("fill", fill, q.size());
        check("overflow", overflow, exp_ovf);
        check("drop_cnt", drop_cnt, exp_drops);
        check("chk_err", chk_err, exp_chk_err);
        check("chk_cnt", chk_cnt, exp_chk_cnt);
        obs_pulses += int'(chk_err);
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) step(0, 0, '0, 1, 0);
    endtask

    initial begin
        s_if.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", s_if.m_valid, 0);
        check("rst_m_data", s_if.m_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_fill", fill, 0);
        check("rst_chk_err", chk_err, 0);
        check("rst_chk_cnt", chk_cnt, 0);
        @(negedge clk);
        reset = 1'b1;

        // Pack order
        step(1, 1, 16'h0001, 0, 0);
        step(1, 1, 16'h0002, 0, 0);
        check("pack_word", s_if.m_data, 32'h0002_0001);
        check("pack_valid", s_if.m_valid, 1);
        drain();

        // Half-word discard on enable drop
        step(1, 1, 16'h00AA, 0, 0);
        step(0, 0, 16'h0000, 0, 0);
        step(1, 1, 16'h0003, 0, 0);
        step(1, 1, 16'h0004, 0, 0);
        check("discard_word", s_if.m_data, 32'h0004_0003);
        check("discard_fill", fill, 1);
        drain();

        // Overflow: 10 words into 8 slots, then clear
        for (int i = 0; i < 20; i++) step(1, 1, 16'(i), 0, 0);
        check("ovf_fill", fill, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_drops", drop_cnt, 2);
        step(0, 0, '0, 0, 1);
        check("clr_flag", overflow, 0);
        check("clr_drops", drop_cnt, 0);
        check("clr_fill", fill, 8);

        // Full FIFO: push and pop on the same edge
        step(1, 1, 16'h1111, 0, 0);
        check("full_head", s_if.m_data, 32'h0001_0000);
        step(1, 1, 16'h2222, 1, 0);
        check("fullpp_fill", fill, 8);
        check("fullpp_drops", drop_cnt, 0);
        check("fullpp_head", s_if.m_data, 32'h0003_0002);
        drain();

        // Random traffic with backpressure, pointers wrap several times
        step(0, 0, '0, 0, 1);
        words_made = 0;
        for (int i = 0; i < 1000 && words_made < 40; i++)
            step(1, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 0);
        check("rand_words", words_made, 40);
        drain();
        check("rand_no_loss", drop_cnt, 0);
        check("rand_empty", s_if.m_valid, 0);

        // Continuity checker
        step(0, 0, '0, 1, 1);
        obs_pulses = 0;
        step(1, 1, 16'd5, 1, 0);
        step(1, 1, 16'd6, 1, 0);
        step(1, 1, 16'd7, 1, 0);
        step(1, 1, 16'd9, 1, 0);
`ifdef ADC_CAPTURE_CHECK_EN
        check("chk_pulses", obs_pulses, 1);
        check("chk_count", chk_cnt, 1);
`else
        check("chk_pulses", obs_pulses, 0);
        check("chk_count", chk_cnt, 0);
`endif
        step(0, 0, '0, 1, 0);
        obs_pulses = 0;
        step(1, 1, 16'd7, 1, 0);
        step(1, 1, 16'd6, 1, 0);
        step(1, 1, 16'd5, 1, 0);
        check("ramp_down_pulses", obs_pulses, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
